// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, responder FSM states and the
// key-code to row/column one-hot decode used by both scanner and responder.
package keypad_pkg;

    localparam int KP_ROWS     = 4;
    localparam int KP_COLS     = 3;
    localparam int KP_NUM_KEYS = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic [KP_ROWS-1:0] row_oh;
        logic [KP_COLS-1:0] col_oh;
        logic               valid;
    } kp_key_t;

    // row = code/3, column = code%3; codes 12-15 decode to all-zero and invalid
    function automatic kp_key_t kp_decode(input logic [3:0] code);
        kp_key_t    k;
        logic [3:0] col_idx;
        k       = '0;
        col_idx = 4'd0;
        if (code < 4'd3) begin
            k.row_oh = 4'b0001;
            col_idx  = code;
        end else if (code < 4'd6) begin
            k.row_oh = 4'b0010;
            col_idx  = code - 4'd3;
        end else if (code < 4'd9) begin
            k.row_oh = 4'b0100;
            col_idx  = code - 4'd6;
        end else if (code < 4'(KP_NUM_KEYS)) begin
            k.row_oh = 4'b1000;
            col_idx  = code - 4'd9;
        end else begin
            k.row_oh = 4'b0000;
        end
        k.valid = (code < 4'(KP_NUM_KEYS));
        case (col_idx)
            4'd0:    k.col_oh = k.valid ? 3'b001 : 3'b000;
            4'd1:    k.col_oh = 3'b010;
            4'd2:    k.col_oh = 3'b100;
            default: k.col_oh = 3'b000;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_responder_if.sv
// Key-request handshake plus scanner-facing column strobe / row return.
// master = requester/scanner side, slave = keypad responder.
interface keypad_responder_if;
    import keypad_pkg::*;

    logic                key_valid;
    logic [3:0]          key_code;
    logic                key_ready;
    logic [KP_COLS-1:0]  columnSel;
    logic [KP_ROWS-1:0]  scanData;
    logic                pressed;
    logic                done;
    logic                err;

    modport master (
        output key_valid, key_code, columnSel,
        input  key_ready, scanData, pressed, done, err
    );

    modport slave (
        input  key_valid, key_code, columnSel,
        output key_ready, scanData, pressed, done, err
    );
endinterface

// File: rtl/keypad_responder_key_map.sv
// Registered decode of an accepted key code into latched row/column
// one-hots, plus a one-cycle error pulse for out-of-range codes.
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [3:0]         code,
    output logic [KP_ROWS-1:0] row_oh,
    output logic [KP_COLS-1:0] col_oh,
    output logic               err
);

    kp_key_t            dec_s;
    logic [KP_ROWS-1:0] row_oh_d, row_oh_q;
    logic [KP_COLS-1:0] col_oh_d, col_oh_q;
    logic               err_d, err_q;

    assign dec_s = kp_decode(code);

    // Latch the decode only for valid accepts so an invalid code cannot disturb the last key
    always_comb begin
        row_oh_d = row_oh_q;
        col_oh_d = col_oh_q;
        err_d    = 1'b0;
        if (load) begin
            if (dec_s.valid) begin
                row_oh_d = dec_s.row_oh;
                col_oh_d = dec_s.col_oh;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // Decode registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_oh_q <= 4'b0000;
            col_oh_q <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            row_oh_q <= row_oh_d;
            col_oh_q <= col_oh_d;
            err_q    <= err_d;
        end
    end

    assign row_oh = row_oh_q;
    assign col_oh = col_oh_q;
    assign err    = err_q;

endmodule

// File: rtl/keypad_responder.sv
// Behavioural 4x3 keypad: accepts key presses and answers column strobes
// with row data, modelling contact bounce, hold and release gap.
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1000,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 8,
    parameter int GAP_CYCLES     = 200
) (
    input  logic                clk,
    input  logic                rst,
    keypad_responder_if.slave   kp
);

    localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_TOGGLES * BOUNCE_PERIOD - 1);
    localparam logic [15:0] PERIOD_LOAD = 16'(BOUNCE_PERIOD - 1);
    localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

    kp_state_e          state_d, state_q;
    logic [15:0]        cnt_d, cnt_q;
    logic [15:0]        phase_d, phase_q;
    logic               open_d, open_q;
    logic               ready_d, ready_q;
    logic               pressed_d, pressed_q;
    logic               done_d, done_q;
    logic [KP_ROWS-1:0] scan_d, scan_q;
    logic               accept_s;
    kp_key_t            dec_s;
    logic [KP_ROWS-1:0] row_oh_s;
    logic [KP_COLS-1:0] col_oh_s;
    logic               err_s;

    assign dec_s    = kp_decode(kp.key_code);
    assign accept_s = kp.key_valid & ready_q;

    keypad_key_map u_key_map (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_s),
        .code   (kp.key_code),
        .row_oh (row_oh_s),
        .col_oh (col_oh_s),
        .err    (err_s)
    );

    // Next-state, counter and registered-output logic; outputs are derived
    // from the next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        open_d  = open_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && dec_s.valid) begin
                    if (BOUNCE_TOGGLES == 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_BOUNCE;
                        cnt_d   = BOUNCE_LOAD;
                        phase_d = PERIOD_LOAD;
                        open_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOUNCE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    open_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                    // Contact flips at every bounce-period boundary
                    if (phase_q == 16'd0) begin
                        phase_d = PERIOD_LOAD;
                        open_d  = ~open_q;
                    end else begin
                        phase_d = phase_q - 16'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_IDLE);
        pressed_d = ((state_d == ST_BOUNCE) && !open_d) || (state_d == ST_HOLD);
        done_d    = (state_d == ST_GAP) && (cnt_d == 16'd0);
        // Row lines wire-OR across every selected column that matches
        if (pressed_q && (|(kp.columnSel & col_oh_s))) begin
            scan_d = row_oh_s;
        end else begin
            scan_d = 4'b0000;
        end
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            phase_q   <= 16'd0;
            open_q    <= 1'b0;
            ready_q   <= 1'b0;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
            scan_q    <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            open_q    <= open_d;
            ready_q   <= ready_d;
            pressed_q <= pressed_d;
            done_q    <= done_d;
            scan_q    <= scan_d;
        end
    end

    assign kp.key_ready = ready_q;
    assign kp.pressed   = pressed_q;
    assign kp.done      = done_q;
    assign kp.scanData  = scan_q;
    assign kp.err       = err_s;

endmodule

// File: doc/keypad_responder.md
# keypad_responder

Behavioural keypad responder: the far end of the 4-row × 3-column keypad scan interface. It accepts key-press commands on a valid/ready port and answers the scanner's column strobes with row data, including contact bounce, hold and release. It sits in place of the physical keypad in FPGA test harnesses and system benches, driving `scanData` into the keypad scanner exactly as the real matrix would.

## Interface
- `HOLD_CYCLES`, 1000: cycles the contact is held closed after bounce.
- `BOUNCE_TOGGLES`, 4: number of bounce periods. Must be even; 0 disables bounce.
- `BOUNCE_PERIOD`, 8: cycles per bounce period (≥1).
- `GAP_CYCLES`, 200: released time after the hold, before the next key is accepted.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `key_valid`  in  1  key-press request.
- `key_code`  in  4  key index 0–11; row = code/3, column = code%3.
- `key_ready`  out  1  responder idle; a request is accepted on `key_valid & key_ready`.
- `columnSel`  in  3  column strobe from the scanner, one-hot, active-high.
- `scanData`  out  4  row return, active-high, registered.
- `pressed`  out  1  contact currently closed (internal contact state).
- `done`  out  1  one-cycle pulse at the end of the gap.
- `err`  out  1  one-cycle pulse when a code of 12–15 is accepted.

## Operation
- FSM states: IDLE, BOUNCE, HOLD, GAP.
- IDLE:
  - `key_ready` = 1.
  - On accept of a valid code: latch the row one-hot and column one-hot, load the counter, and go to BOUNCE. If `BOUNCE_TOGGLES` = 0, go directly to HOLD.
  - On accept of a code of 12–15: pulse `err` the next cycle and stay in IDLE. No contact activity.
- BOUNCE:
  - Lasts `BOUNCE_TOGGLES` × `BOUNCE_PERIOD` cycles.
  - Contact is closed in even-indexed periods (0, 2, …) and open in odd-indexed periods.
  - Then go to HOLD.
- HOLD: contact closed for `HOLD_CYCLES` cycles, then go to GAP.
- GAP: contact open for `GAP_CYCLES` cycles. On the last cycle, pulse `done` and go to IDLE.
- `key_ready` = 0 in every state except IDLE. `key_valid` is ignored while busy.
- Row return is computed as `scanData_next` = latched row one-hot if (contact & |(`columnSel` & latched column one-hot)), else 0.
- Column-strobe cases:
  - Non-one-hot `columnSel`: the rule above still applies, i.e. the row lines are wire-OR'd across selected columns.
  - `columnSel` = 0 gives 0.
- Counter: 16-bit down-counter, reloaded at each state entry. Parameters must fit 16 bits.
- Reset (`rst` low at an edge), including mid-press:
  - State → IDLE; `scanData`, `pressed`, `done`, `err` → 0.
  - `key_ready` → 1 on the first cycle after reset deasserts.

## Timing
- Accept at edge T: `pressed` = 1 from T+1.
- `scanData` lags `columnSel` and contact by exactly 1 cycle (registered output).
- Total busy time: `BOUNCE_TOGGLES` × `BOUNCE_PERIOD` + `HOLD_CYCLES` + `GAP_CYCLES` cycles.
  - `done` is high in cycle T + that total.
  - `key_ready` = 1 in the following cycle.
- Back-to-back requests: a `key_valid` held high is accepted in the first IDLE cycle after `done`.
- `err` is high in cycle T+1 for an invalid code; `key_ready` stays 1 throughout.

## Structure
- Package `keypad_pkg`:
  - constants `KP_ROWS` = 4, `KP_COLS` = 3, `KP_NUM_KEYS` = 12;
  - FSM state enum;
  - code→(row one-hot, column one-hot) function.
  - The keypad scanner's verification shares this package.
- One natural sub-module, `keypad_key_map`: registered decode of `key_code` to row/column one-hots plus the invalid flag.
- Everything else is one FSM + counter process.

## Test plan
Common parameters: `HOLD_CYCLES` = 20, `BOUNCE_TOGGLES` = 4, `BOUNCE_PERIOD` = 3, `GAP_CYCLES` = 10.
- Reset: hold `rst` = 0 for 3 cycles with `key_valid` = 1 → all outputs 0 during reset; `key_ready` = 1 after release.
- Key 5 (row 1, column 2), `columnSel` fixed at 3'b100:
  - `pressed` pattern is 1,1,1,0,0,0,1,1,1,0,0,0, then 20 × 1, then 10 × 0;
  - `scanData` = 4'b0010 whenever `pressed` was 1 in the prior cycle;
  - `done` is high at T+42.
- Same key, `columnSel` rotating 001→010→100 every cycle during HOLD → `scanData` = 4'b0010 only in the cycle after 100 was presented, else 0.
- Key 13 → `err` pulses at T+1; `pressed` stays 0; no `done`.
- Key 0 then key 11 with `key_valid` held high → second accept at T+43; then `scanData` = 4'b1000 under `columnSel` = 3'b100.
- Reset asserted mid-HOLD → `scanData`/`pressed` = 0 next cycle; a new key-3 request is accepted right after reset deasserts.
